pipeline_fetch: RTL and testbench

// - IF stage of the 5-stage pipeline. It is the consumer of EXE's redirection_e_o/redirection_pc_e_o and the producer of taken/prediction_pc for ID->EXE.
// - Owns the PC and drives a 1-cycle-latency instruction memory port.
// - Contains a static branch predictor: backward B-type and JAL are predicted taken; JALR is always predicted not-taken.
// - Flushes wrong-path fetches on an EXE redirect or a trap, and holds its output across ID stalls using a 1-entry skid buffer.

---
 rtl/pipeline_fetch_pkg.sv | 32 +++
 rtl/pipeline_fetch_sbp_predecode.sv | 43 ++++
 rtl/pipeline_fetch.sv | 119 +++++++++++
 tb/tb_pipeline_fetch.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_fetch_pkg.sv
// Shared definitions for the IF stage: opcodes, FSM encodings and the F/D entry layout.
package pipeline_fetch_pkg;

    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        taken;
        logic [31:0] pred_pc;
    } fetch_entry_t;

    localparam fetch_entry_t FD_RESET = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0,
                                          taken: 1'b0, pred_pc: '0};

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/pipeline_fetch_sbp_predecode.sv
// Static branch predictor: backward B-type and JAL predicted taken, everything else falls through.
module sbp_predecode
    import pipeline_fetch_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic        taken,
    output logic [31:0] target,
    output logic [31:0] prediction_pc
);

    logic [31:0] pc_plus4;
    logic [31:0] br_tgt;
    logic [31:0] jal_tgt;

    assign pc_plus4 = pc + 32'd4;
    assign br_tgt   = pc + imm_b(instr);
    assign jal_tgt  = pc + imm_j(instr);

    // target is always the next fetch address: predicted target or fall-through
    always_comb begin
        taken         = 1'b0;
        target        = pc_plus4;
        prediction_pc = pc_plus4;
        case (instr[6:0])
            OPC_BRANCH: begin
                if (instr[31]) begin
                    taken  = 1'b1;
                    target = br_tgt;
                end else begin
                    prediction_pc = br_tgt;
                end
            end
            OPC_JAL: begin
                taken  = 1'b1;
                target = jal_tgt;
            end
            OPC_JALR: ;
            default: ;
        endcase
    end

endmodule

// File: rtl/pipeline_fetch.sv
// IF stage: PC/FSM, 1-cycle imem port, static prediction, kill handling and a 1-entry skid buffer.
module pipeline_fetch
    import pipeline_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirection_e_i,
    input  logic [31:0] redirection_pc_e_i,
    input  logic        trap_redirect_t_i,
    input  logic [31:0] trap_pc_t_i,
    input  logic        stall_f_i,
    output logic        valid_f_o,
    output logic [31:0] instr_f_o,
    output logic [31:0] pc_f_o,
    output logic [31:0] pc_plus4_f_o,
    output logic        taken_f_o,
    output logic [31:0] prediction_pc_f_o
);

    logic [1:0]   state_q, state_d;
    logic [31:0]  addr_q, next_addr;
    logic         inflight_q;
    logic [31:0]  inflight_pc_q;
    logic         kill, resp_live, granted;
    logic         pd_taken;
    logic [31:0]  pd_target, pd_pred;
    fetch_entry_t resp, skid_q, fd_q;
    logic         skid_vld_q, fd_vld_q;

    assign kill      = trap_redirect_t_i | redirection_e_i;
    assign resp_live = imem_rvalid_i & inflight_q & ~kill;

    sbp_predecode u_predecode (
        .instr         (imem_rdata_i),
        .pc            (inflight_pc_q),
        .taken         (pd_taken),
        .target        (pd_target),
        .prediction_pc (pd_pred)
    );

    assign resp = '{instr: imem_rdata_i, pc: inflight_pc_q, pc_plus4: inflight_pc_q + 32'd4,
                    taken: pd_taken, pred_pc: pd_pred};

    always_comb begin
        if (trap_redirect_t_i)    next_addr = trap_pc_t_i;
        else if (redirection_e_i) next_addr = redirection_pc_e_i;
        else if (resp_live)       next_addr = pd_target;
        else                      next_addr = addr_q;
    end

    assign imem_addr_o = next_addr & ~32'd3;
    // No request while stalled so at most one response can land in the skid buffer.
    assign imem_req_o  = (state_q != ST_BOOT) && (kill || (state_q == ST_RUN && !stall_f_i));
    assign granted     = imem_req_o & imem_gnt_i;

    always_comb begin
        state_d = state_q;
        if (kill) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_BOOT: state_d = ST_RUN;
                ST_RUN:  if (stall_f_i)  state_d = ST_HOLD;
                ST_HOLD: if (!stall_f_i) state_d = ST_RUN;
                default: state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_BOOT;
            addr_q        <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            skid_vld_q    <= 1'b0;
            skid_q        <= FD_RESET;
            fd_vld_q      <= 1'b0;
            fd_q          <= FD_RESET;
        end else begin
            state_q    <= state_d;
            addr_q     <= imem_addr_o;
            inflight_q <= granted;
            if (granted) inflight_pc_q <= imem_addr_o;

            if (kill) begin
                skid_vld_q <= 1'b0;
                fd_vld_q   <= 1'b0;
            end else if (stall_f_i) begin
                if (resp_live) begin
                    skid_vld_q <= 1'b1;
                    skid_q     <= resp;
                end
            end else if (skid_vld_q) begin
                fd_vld_q   <= 1'b1;
                fd_q       <= skid_q;
                skid_vld_q <= 1'b0;
            end else begin
                fd_vld_q <= resp_live;
                if (resp_live) fd_q <= resp;
            end
        end
    end

    assign valid_f_o         = fd_vld_q;
    assign instr_f_o         = fd_q.instr;
    assign pc_f_o            = fd_q.pc;
    assign pc_plus4_f_o      = fd_q.pc_plus4;
    assign taken_f_o         = fd_q.taken;
    assign prediction_pc_f_o = fd_q.pred_pc;

endmodule

// File: tb/tb_pipeline_fetch.sv
// Bench for pipeline_fetch: directed scenarios plus random traffic against a program-order stream model.
module tb_pipeline_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        redirection_e_i = 1'b0;
    logic [31:0] redirection_pc_e_i = '0;
    logic        trap_redirect_t_i = 1'b0;
    logic [31:0] trap_pc_t_i = '0;
    logic        stall_f_i = 1'b0;
    logic        valid_f_o;
    logic [31:0] instr_f_o, pc_f_o, pc_plus4_f_o, prediction_pc_f_o;
    logic        taken_f_o;

    always #5 clk = ~clk;

    pipeline_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .resetn(resetn),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .redirection_e_i(redirection_e_i), .redirection_pc_e_i(redirection_pc_e_i),
        .trap_redirect_t_i(trap_redirect_t_i), .trap_pc_t_i(trap_pc_t_i),
        .stall_f_i(stall_f_i), .valid_f_o(valid_f_o), .instr_f_o(instr_f_o),
        .pc_f_o(pc_f_o), .pc_plus4_f_o(pc_plus4_f_o), .taken_f_o(taken_f_o),
        .prediction_pc_f_o(prediction_pc_f_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // program memory, aliased every 256 bytes
    logic [31:0] mem [64];
    function automatic logic [31:0] mem_at(input logic [31:0] a);
        return mem[a[7:2]];
    endfunction

    // architectural meaning of an instruction at pc: fall-through / predicted next / alternate
    function automatic void ref_decode(input logic [31:0] pc, output logic taken,
                                       output logic [31:0] nxt, output logic [31:0] alt);
        logic [31:0] w;
        int off_b, off_j;
        w = mem_at(pc);
        off_b = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        off_j = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
              + int'(w[30:21]) * 2;
        taken = 1'b0;
        nxt   = pc + 32'd4;
        alt   = pc + 32'd4;
        if (w[6:0] == 7'b1100011) begin
            if (w[31]) begin taken = 1'b1; nxt = pc + 32'(off_b); end
            else alt = pc + 32'(off_b);
        end else if (w[6:0] == 7'b1101111) begin
            taken = 1'b1;
            nxt   = pc + 32'(off_j);
        end
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0013;
            1, 2:    return {r[31:7], 7'b1100011};
            3:       return {r[31:7], 7'b1101111};
            4:       return {r[31:7], 7'b1100111};
            default: return {r[31:7], 7'b0110011};
        endcase
    endfunction

    // per-cycle knobs and observation state
    logic        k_rst = 1'b0, k_gnt = 1'b1, k_stall = 1'b0, k_redir = 1'b0, k_trap = 1'b0;
    logic [31:0] k_rpc = '0, k_tpc = '0;
    logic        pend_v = 1'b0;
    logic [31:0] pend_a = '0;
    logic [31:0] exp_pc = RESET_PC;
    int          since_rst = 0, cyc = 0, first_grant = -1, first_valid = -1, consumed = 0;
    logic [31:0] first_valid_pc = '0;
    logic [31:0] grants [$];
    logic [31:0] watch_pc = '0, watch_pred = '0;
    logic        watch_hit = 1'b0, watch_taken = 1'b0;
    logic        s_valid, s_taken, s_req;
    logic [31:0] s_instr, s_pc, s_pc4, s_pred, s_addr;
    logic        p_valid, p_taken, p_stall = 1'b0, p_kill = 1'b0;
    logic [31:0] p_instr, p_pc, p_pc4, p_pred;

    function automatic logic [31:0] grant_at(input int k);
        return (grants.size() > k) ? grants[k] : 32'hDEAD_BEEF;
    endfunction

    task automatic step();
        logic        kill, tk;
        logic [31:0] kpc, nx, alt;
        @(negedge clk);
        cyc++;
        s_valid = valid_f_o; s_instr = instr_f_o; s_pc = pc_f_o; s_pc4 = pc_plus4_f_o;
        s_taken = taken_f_o; s_pred = prediction_pc_f_o;
        resetn = k_rst; imem_gnt_i = k_gnt; stall_f_i = k_stall;
        redirection_e_i = k_redir; redirection_pc_e_i = k_rpc;
        trap_redirect_t_i = k_trap; trap_pc_t_i = k_tpc;
        imem_rvalid_i = pend_v;
        imem_rdata_i  = pend_v ? mem_at(pend_a) : $urandom;
        #1;
        s_req = imem_req_o; s_addr = imem_addr_o;
        kill = k_trap | k_redir;
        kpc  = (k_trap ? k_tpc : k_rpc) & ~32'd3;
        if (!k_rst) begin
            since_rst = 0; exp_pc = RESET_PC; grants.delete();
            first_grant = -1; first_valid = -1;
        end else begin
            since_rst++;
            if (since_rst == 1) begin
                chk("rst_valid", 32'(s_valid), 32'd0);
                chk("rst_instr", s_instr, 32'h0000_0013);
                chk("rst_pc", s_pc, 32'd0);
                chk("rst_pc4", s_pc4, 32'd0);
                chk("rst_taken", 32'(s_taken), 32'd0);
                chk("rst_pred", s_pred, 32'd0);
                chk("rst_req", 32'(s_req), 32'd0);
            end
            if (since_rst >= 2 && p_stall && !p_kill) begin
                chk("hold_valid", 32'(s_valid), 32'(p_valid));
                chk("hold_instr", s_instr, p_instr);
                chk("hold_pc", s_pc, p_pc);
                chk("hold_pc4", s_pc4, p_pc4);
                chk("hold_taken", 32'(s_taken), 32'(p_taken));
                chk("hold_pred", s_pred, p_pred);
            end
            if (since_rst >= 3 && p_stall && k_stall && !p_kill && !kill)
                chk("hold_req", 32'(s_req), 32'd0);
            if (s_req) chk("addr_align", 32'(s_addr[1:0]), 32'd0);
            if (kill) begin
                chk("kill_addr", s_addr, kpc);
                if (since_rst >= 2) chk("kill_req", 32'(s_req), 32'd1);
            end
            if (s_valid && first_valid < 0) begin first_valid = cyc; first_valid_pc = s_pc; end
            if (s_valid && s_pc == watch_pc && !watch_hit) begin
                watch_hit = 1'b1; watch_taken = s_taken; watch_pred = s_pred;
            end
            if (s_valid && !k_stall && !kill) begin
                ref_decode(exp_pc, tk, nx, alt);
                chk("stream_pc", s_pc, exp_pc);
                chk("stream_instr", s_instr, mem_at(exp_pc));
                chk("stream_pc4", s_pc4, exp_pc + 32'd4);
                chk("stream_taken", 32'(s_taken), 32'(tk));
                chk("stream_pred", s_pred, alt);
                exp_pc = nx & ~32'd3;
                consumed++;
            end
            if (kill) exp_pc = kpc;
            if (s_req && k_gnt) begin
                grants.push_back(s_addr);
                if (first_grant < 0) first_grant = cyc;
            end
        end
        pend_v = s_req & k_gnt;
        pend_a = s_addr;
        p_valid = s_valid; p_instr = s_instr; p_pc = s_pc; p_pc4 = s_pc4;
        p_taken = s_taken; p_pred = s_pred; p_stall = k_stall; p_kill = kill;
    endtask

    task automatic do_reset();
        k_rst = 1'b0; step(); step(); k_rst = 1'b1;
        watch_hit = 1'b0;
    endtask

    initial begin
        logic [31:0] snap;
        int stall_left;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;

        // sequential nops, then a backward beq at 0x10
        mem[4] = 32'hFE00_0AE3;
        watch_pc = 32'h8000_0010;
        do_reset();
        repeat (12) step();
        chk("seq_grant0", grant_at(0), 32'h8000_0000);
        chk("seq_grant1", grant_at(1), 32'h8000_0004);
        chk("seq_grant2", grant_at(2), 32'h8000_0008);
        chk("bwd_grant", grant_at(4), 32'h8000_0010);
        chk("bwd_target", grant_at(5), 32'h8000_0004);
        chk("first_latency", 32'(first_valid - first_grant), 32'd2);
        chk("first_pc", first_valid_pc, 32'h8000_0000);
        chk("bwd_seen", 32'(watch_hit), 32'd1);
        chk("bwd_taken", 32'(watch_taken), 32'd1);
        chk("bwd_pred", watch_pred, 32'h8000_0014);

        // forward beq at 0x20 falls through
        mem[4] = 32'h0000_0013;
        mem[8] = 32'h0000_0863;
        watch_pc = 32'h8000_0020;
        do_reset();
        repeat (16) step();
        chk("fwd_grant", grant_at(8), 32'h8000_0020);
        chk("fwd_next", grant_at(9), 32'h8000_0024);
        chk("fwd_seen", 32'(watch_hit), 32'd1);
        chk("fwd_taken", 32'(watch_taken), 32'd0);
        chk("fwd_pred", watch_pred, 32'h8000_0030);

        // redirect with a response in flight
        k_redir = 1'b1; k_rpc = 32'h8000_0100;
        step();
        chk("redir_addr", s_addr, 32'h8000_0100);
        k_redir = 1'b0;
        step();
        chk("redir_drop", 32'(s_valid), 32'd0);
        step();
        chk("redir_first_valid", 32'(s_valid), 32'd1);
        chk("redir_first_pc", s_pc, 32'h8000_0100);

        // 3-cycle stall while a response returns, then skid drain
        k_stall = 1'b1;
        step();
        snap = s_pc;
        step();
        chk("stall_req", 32'(s_req), 32'd0);
        step();
        chk("stall_req2", 32'(s_req), 32'd0);
        chk("stall_pc", s_pc, snap);
        k_stall = 1'b0;
        step();
        chk("release_pc", s_pc, snap);
        step();
        chk("skid_valid", 32'(s_valid), 32'd1);
        chk("skid_pc", s_pc, snap + 32'd4);
        chk("skid_next_req", 32'(s_req), 32'd1);
        chk("skid_next_addr", s_addr, snap + 32'd8);

        // trap beats redirect, then reset during a stall
        k_trap = 1'b1; k_tpc = 32'h8000_0200; k_redir = 1'b1; k_rpc = 32'h8000_0100;
        step();
        chk("trap_wins", s_addr, 32'h8000_0200);
        k_trap = 1'b0; k_redir = 1'b0; k_stall = 1'b1;
        repeat (3) step();
        k_rst = 1'b0;
        step();
        k_rst = 1'b1;
        step();
        chk("midstall_rst_valid", 32'(s_valid), 32'd0);
        k_stall = 1'b0;

        // random traffic
        for (int i = 0; i < 64; i++) mem[i] = rand_instr();
        do_reset();
        consumed = 0;
        stall_left = 0;
        for (int n = 0; n < 4000; n++) begin
            k_gnt = ($urandom_range(0, 3) != 0);
            if (stall_left > 0) stall_left--;
            else if ($urandom_range(0, 5) == 0) stall_left = $urandom_range(1, 4);
            k_stall = (stall_left > 0);
            k_redir = ($urandom_range(0, 24) == 0);
            k_rpc   = 32'h8000_0000 | $urandom_range(0, 32'h3ff);
            k_trap  = ($urandom_range(0, 59) == 0);
            k_tpc   = 32'h8000_0000 | $urandom_range(0, 32'h3ff);
            k_rst   = ($urandom_range(0, 399) != 0);
            step();
        end
        k_rst = 1'b1; k_redir = 1'b0; k_trap = 1'b0; k_stall = 1'b0;
        step();
        chk("rand_progress", 32'(consumed > 300), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
